// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package imem_loader_pkg;
    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 16;
    localparam int BYTES_PER_WORD = 2;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DAT_HI,
        DAT_LO,
        RUN,
        DONE,
        ERR
    } state_t;
endpackage

// File: rtl/imem_loader_byte_pair_assembler.sv
// Joins two handshaked bytes (high first) into a registered word with a one-cycle valid.
module byte_pair_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic              low,
    input  logic [7:0]        data,
    output logic [7:0]        hi,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= accept && low;
            if (accept && !low) hi   <= data;
            if (accept && low)  word <= {hi, data};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes instruction memory,
// then releases the core and counts its execution cycles until it halts.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_WORDS = 1024,
    parameter int CYC_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic              done,
    output logic              error,
    output logic [CYC_W-1:0]  cycle_count
);

    state_t            state, state_next;
    logic              accept, low_phase, header_bad, last_word;
    logic [7:0]        asm_hi;
    logic [DATA_W-1:0] asm_word;
    logic              asm_valid;
    logic [15:0]       header, len_q;
    logic [ADDR_W-1:0] index, addr_q;
    logic              wr_pending;
    logic [DATA_W-1:0] wdata_hold;

    assign accept     = in_valid && in_ready;
    assign low_phase  = (state == LEN_LO) || (state == DAT_LO);
    assign header     = {asm_hi, in_data};
    assign header_bad = (header == 16'd0) || (32'(header) > MAX_WORDS);
    assign last_word  = (32'(index) == (32'(len_q) - 32'd1));

    byte_pair_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept),
        .low        (low_phase),
        .data       (in_data),
        .hi         (asm_hi),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LEN_HI;
        else        state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_next = header_bad ? ERR : DAT_HI;
            end
            DAT_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = DAT_LO;
            end
            DAT_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_next = last_word ? RUN : DAT_HI;
            end
            // The first RUN cycle carries the final write; the core is still held then.
            RUN:     if (cpu_run && cpu_halted) state_next = DONE;
            DONE:    state_next = DONE;
            ERR:     state_next = ERR;
            default: state_next = LEN_HI;
        endcase
    end

    assign done       = (state == DONE);
    assign error      = (state == ERR);
    assign imem_we    = asm_valid && wr_pending;
    assign imem_addr  = addr_q;
    assign imem_wdata = imem_we ? asm_word : wdata_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q       <= '0;
            index       <= '0;
            addr_q      <= '0;
            wr_pending  <= 1'b0;
            wdata_hold  <= '0;
            cpu_run     <= 1'b0;
            cycle_count <= '0;
        end else begin
            wr_pending <= accept && (state == DAT_LO);
            if (accept && (state == LEN_LO)) begin
                len_q <= header;
                index <= '0;
            end
            if (accept && (state == DAT_LO)) begin
                addr_q <= index;
                index  <= index + 1'b1;
            end
            if (imem_we) wdata_hold <= asm_word;
            cpu_run <= (state == RUN) || (state == DONE);
            if ((state == RUN) && cpu_run && !cpu_halted && (cycle_count != '1))
                cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against a word-list/cycle-count model.
module tb_imem_loader;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 16;
    localparam int MAX_WORDS = 1024;
    localparam int CYC_W     = 4;
    localparam int CNT_MAX   = (1 << CYC_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              cpu_halted = 1'b0;
    logic              in_ready, imem_we, cpu_run, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic [CYC_W-1:0]  cycle_count;

    imem_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .done(done), .error(error), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int we_cnt = 0;
    logic [15:0] prog [0:1023];
    int prog_len = 0;

    always @(negedge clk) if (imem_we === 1'b1) we_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic int gap_of(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (in_ready !== 1'b1) $display("FAIL send_byte_ready: in_ready=%b required 1 within 50 cycles", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [15:0] w, input int a, input int gap_hi, input int gap_lo);
        send_byte(w[15:8]);
        idle(gap_hi);
        send_byte(w[7:0]);
        @(negedge clk);
        total++;
        if (imem_we !== 1'b1 || imem_addr !== a[ADDR_W-1:0] || imem_wdata !== w)
            $display("FAIL write_%0d: we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                     a, imem_we, imem_addr, imem_wdata, a, w);
        else passed++;
        idle(gap_lo);
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        cpu_halted = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({in_ready, imem_we, cpu_run, done, error} !== 5'b10000)
            $display("FAIL reset_flags: rdy/we/run/done/err=%b required 10000",
                     {in_ready, imem_we, cpu_run, done, error});
        else passed++;
        total++;
        if (imem_addr !== '0 || imem_wdata !== '0)
            $display("FAIL reset_bus: addr=%0d data=%h required 0/0000", imem_addr, imem_wdata);
        else passed++;
        total++;
        if (cycle_count !== '0) $display("FAIL reset_count: count=%0d required 0", cycle_count);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Loads prog[0..prog_len-1], lets the core run for run_cycles before halting, checks everything.
    task automatic run_program(input int mode, input int run_cycles, input bit halt_in_load, input bit valid_in_run);
        int we0, exp_cnt;
        logic [15:0] lenv;
        we0     = we_cnt;
        exp_cnt = (run_cycles > CNT_MAX) ? CNT_MAX : run_cycles;
        lenv    = 16'(prog_len);
        cpu_halted = halt_in_load;
        send_byte(lenv[15:8]);
        idle(gap_of(mode));
        send_byte(lenv[7:0]);
        idle(gap_of(mode));
        for (int i = 0; i < prog_len; i++)
            send_word(prog[i], i, gap_of(mode), (i == prog_len - 1) ? 0 : gap_of(mode));
        total++;
        if (cpu_run !== 1'b0) $display("FAIL run_early: cpu_run=%b during last write, required 0", cpu_run);
        else passed++;
        cpu_halted = (run_cycles == 0);
        if (valid_in_run) begin in_valid = 1'b1; in_data = 8'($urandom); end
        @(negedge clk);
        total++;
        if (cpu_run !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0)
            $display("FAIL run_start: run/ready/we=%b%b%b required 100", cpu_run, in_ready, imem_we);
        else passed++;
        total++;
        if (imem_addr !== ADDR_W'(prog_len - 1) || imem_wdata !== prog[prog_len - 1])
            $display("FAIL bus_hold: addr=%0d data=%h required %0d/%h",
                     imem_addr, imem_wdata, prog_len - 1, prog[prog_len - 1]);
        else passed++;
        if (run_cycles > 0) begin
            repeat (run_cycles) @(posedge clk);
            #1 cpu_halted = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || cpu_run !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL done_flags: done/run/err/rdy=%b%b%b%b required 1100", done, cpu_run, error, in_ready);
        else passed++;
        total++;
        if (cycle_count !== CYC_W'(exp_cnt))
            $display("FAIL cycle_count: count=%0d required %0d", cycle_count, exp_cnt);
        else passed++;
        total++;
        if (we_cnt - we0 !== prog_len)
            $display("FAIL write_pulses: pulses=%0d required %0d", we_cnt - we0, prog_len);
        else passed++;
        cpu_halted = 1'b0;
        idle(3);
        @(negedge clk);
        total++;
        if (done !== 1'b1 || cycle_count !== CYC_W'(exp_cnt))
            $display("FAIL done_frozen: done=%b count=%0d required 1/%0d", done, cycle_count, exp_cnt);
        else passed++;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        prog_len = 3;
        prog[0] = 16'h1001; prog[1] = 16'h2002; prog[2] = 16'hF000;
        run_program(0, 7, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_reset();
        prog_len = 3;
        prog[0] = 16'h1001; prog[1] = 16'h2002; prog[2] = 16'hF000;
        run_program(1, 7, 1'b0, 1'b0);
    endtask

    task automatic test_bad_header(input logic [7:0] hi, input logic [7:0] lo);
        int we0;
        do_reset();
        we0 = we_cnt;
        send_byte(hi);
        send_byte(lo);
        @(negedge clk);
        total++;
        if ({error, in_ready, cpu_run, done} !== 4'b1000)
            $display("FAIL bad_header_%h%h: err/rdy/run/done=%b required 1000", hi, lo,
                     {error, in_ready, cpu_run, done});
        else passed++;
        in_valid = 1'b1;
        cpu_halted = 1'b1;
        for (int i = 0; i < 4; i++) begin in_data = 8'($urandom); @(posedge clk); #1; end
        in_valid = 1'b0;
        cpu_halted = 1'b0;
        @(negedge clk);
        total++;
        if (error !== 1'b1 || in_ready !== 1'b0 || cpu_run !== 1'b0 || we_cnt !== we0)
            $display("FAIL err_terminal: err=%b rdy=%b run=%b writes=%0d required 1/0/0/0",
                     error, in_ready, cpu_run, we_cnt - we0);
        else passed++;
    endtask

    task automatic test_reset_midload();
        do_reset();
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(16'hAAAA, 0, 0, 0);
        send_word(16'h5555, 1, 0, 0);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({in_ready, imem_we, cpu_run, done, error} !== 5'b10000 || imem_addr !== '0 || imem_wdata !== '0)
            $display("FAIL midload_reset: flags=%b addr=%0d data=%h required 10000/0/0000",
                     {in_ready, imem_we, cpu_run, done, error}, imem_addr, imem_wdata);
        else passed++;
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        prog_len = 1;
        prog[0] = 16'h1234;
        run_program(0, 3, 1'b0, 1'b0);
    endtask

    task automatic test_saturate();
        do_reset();
        prog_len = 2;
        prog[0] = 16'hCAFE; prog[1] = 16'hBEEF;
        run_program(0, 20, 1'b0, 1'b0);
        do_reset();
        run_program(0, 16, 1'b0, 1'b0);
    endtask

    task automatic test_ignore();
        do_reset();
        prog_len = 3;
        for (int i = 0; i < 3; i++) prog[i] = 16'($urandom);
        run_program(2, 5, 1'b1, 1'b1);
    endtask

    task automatic test_max_len();
        do_reset();
        prog_len = MAX_WORDS;
        for (int i = 0; i < MAX_WORDS; i++) prog[i] = 16'($urandom);
        run_program(0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            do_reset();
            prog_len = int'($urandom_range(1, 12));
            for (int i = 0; i < prog_len; i++) prog[i] = 16'($urandom);
            run_program(2, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_bad_header(8'h00, 8'h00);
        test_bad_header(8'h04, 8'h01);
        test_reset_midload();
        test_saturate();
        test_ignore();
        test_max_len();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
